// File: rtl/des_pkg.sv
// DES permutation package: IP / IP-inverse index tables, mode encoding and
// the two permutation helpers used ahead of the first pipeline stage.
// Bit numbering follows DES: bit 1 is the MSB, held at vector index 64.
package des_pkg;

    localparam int unsigned DATA_W = 64;

    localparam logic MODE_IP = 1'b0;
    localparam logic MODE_FP = 1'b1;

    // out[i] = in[IP_TABLE[i-1]]
    localparam int unsigned IP_TABLE [64] = '{
        58, 50, 42, 34, 26, 18, 10,  2,
        60, 52, 44, 36, 28, 20, 12,  4,
        62, 54, 46, 38, 30, 22, 14,  6,
        64, 56, 48, 40, 32, 24, 16,  8,
        57, 49, 41, 33, 25, 17,  9,  1,
        59, 51, 43, 35, 27, 19, 11,  3,
        61, 53, 45, 37, 29, 21, 13,  5,
        63, 55, 47, 39, 31, 23, 15,  7
    };

    // out[i] = in[FP_TABLE[i-1]]
    localparam int unsigned FP_TABLE [64] = '{
        40,  8, 48, 16, 56, 24, 64, 32,
        39,  7, 47, 15, 55, 23, 63, 31,
        38,  6, 46, 14, 54, 22, 62, 30,
        37,  5, 45, 13, 53, 21, 61, 29,
        36,  4, 44, 12, 52, 20, 60, 28,
        35,  3, 43, 11, 51, 19, 59, 27,
        34,  2, 42, 10, 50, 18, 58, 26,
        33,  1, 41,  9, 49, 17, 57, 25
    };

    // DES bit k lives at vector index 65-k.
    function automatic logic [DATA_W:1] ip_perm(input logic [DATA_W:1] d);
        logic [DATA_W:1] r;
        r = '0;
        for (int i = 0; i < 64; i++) begin
            r[7'(64 - i)] = d[7'(65 - IP_TABLE[6'(i)])];
        end
        return r;
    endfunction

    function automatic logic [DATA_W:1] fp_perm(input logic [DATA_W:1] d);
        logic [DATA_W:1] r;
        r = '0;
        for (int i = 0; i < 64; i++) begin
            r[7'(64 - i)] = d[7'(65 - FP_TABLE[6'(i)])];
        end
        return r;
    endfunction

endpackage

// File: rtl/des_perm_stage.sv
// One elastic register stage: holds a valid word plus tag and accepts a new
// word when empty or when its own word leaves in the same cycle.
module des_perm_stage
    import des_pkg::*;
#(
    parameter int unsigned TAG_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              up_valid,
    output logic              up_ready_c,
    input  logic [DATA_W:1]   up_data,
    input  logic [TAG_W-1:0]  up_tag,
    output logic              dn_valid,
    input  logic              dn_ready,
    output logic [DATA_W:1]   dn_data,
    output logic [TAG_W-1:0]  dn_tag
);

    logic             valid_q, valid_d;
    logic [DATA_W:1]  data_q,  data_d;
    logic [TAG_W-1:0] tag_q,   tag_d;

    // Next-state: ready when empty or draining; load only on an upstream transfer.
    always_comb begin
        up_ready_c = !valid_q || dn_ready;
        valid_d    = valid_q;
        data_d     = data_q;
        tag_d      = tag_q;
        if (up_ready_c) begin
            valid_d = up_valid;
        end
        if (up_valid && up_ready_c) begin
            data_d = up_data;
            tag_d  = up_tag;
        end
    end

    // Valid bit is the only reset state in the stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Payload registers are deliberately left unreset.
    always_ff @(posedge clk) begin
        data_q <= data_d;
        tag_q  <= tag_d;
    end

    assign dn_valid = valid_q;
    assign dn_data  = data_q;
    assign dn_tag   = tag_q;

endmodule

// File: rtl/des_perm_pipe.sv
// DES IP / FP permutation followed by STAGES elastic register stages.
// Define DES_PERM_FP_EN to add the FP (IP-inverse) path selected by in_mode;
// without it every word receives IP and in_mode is ignored.
module des_perm_pipe
    import des_pkg::*;
#(
    parameter int unsigned STAGES = 2,
    parameter int unsigned TAG_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_mode,
    input  logic [TAG_W-1:0]  in_tag,
    input  logic [64:1]       in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [64:1]       out,
    output logic [TAG_W-1:0]  out_tag,
    output logic [2:0]        occupancy
);

    logic [DATA_W:1]                perm_c;
    logic [STAGES-1:0]              stg_vld;
    logic [STAGES-1:0]              stg_rdy;
    logic [STAGES-1:0]              dn_rdy_c;
    logic [STAGES-1:0][DATA_W-1:0]  stg_data;
    logic [STAGES-1:0][TAG_W-1:0]   stg_tag;
    logic [2:0]                     occ_q, occ_d;
    logic                           in_fire_c;
    logic                           out_fire_c;
    logic                           unused_rdy;

    // Permutation sits in front of stage 1; later stages only hold data.
`ifdef DES_PERM_FP_EN
    always_comb begin
        perm_c = (in_mode == MODE_FP) ? fp_perm(in) : ip_perm(in);
    end
`else
    logic unused_mode;
    assign unused_mode = in_mode;
    always_comb begin
        perm_c = ip_perm(in);
    end
`endif

    // Downstream ready per stage: out_ready, or any empty slot further along.
    always_comb begin
        logic acc;
        acc      = out_ready;
        dn_rdy_c = '0;
        for (int k = int'(STAGES) - 1; k >= 0; k--) begin
            dn_rdy_c[k] = acc;
            acc         = acc || !stg_vld[k];
        end
    end

    for (genvar k = 0; k < int'(STAGES); k++) begin : g_stage
        logic             up_v;
        logic [DATA_W:1]  up_d;
        logic [TAG_W-1:0] up_t;

        if (k == 0) begin : g_head
            assign up_v = in_valid;
            assign up_d = perm_c;
            assign up_t = in_tag;
        end else begin : g_body
            assign up_v = stg_vld[k-1];
            assign up_d = stg_data[k-1];
            assign up_t = stg_tag[k-1];
        end

        des_perm_stage #(
            .TAG_W      (TAG_W)
        ) u_stage (
            .clk        (clk),
            .rst        (rst),
            .up_valid   (up_v),
            .up_ready_c (stg_rdy[k]),
            .up_data    (up_d),
            .up_tag     (up_t),
            .dn_valid   (stg_vld[k]),
            .dn_ready   (dn_rdy_c[k]),
            .dn_data    (stg_data[k]),
            .dn_tag     (stg_tag[k])
        );
    end

    // Inner stage readies duplicate dn_rdy_c; only stage 1 drives in_ready.
    assign unused_rdy = ^stg_rdy;

    assign in_ready   = stg_rdy[0] && !rst;
    assign out_valid  = stg_vld[STAGES-1];
    assign out        = stg_data[STAGES-1];
    assign out_tag    = stg_tag[STAGES-1];
    assign in_fire_c  = in_valid && in_ready;
    assign out_fire_c = out_valid && out_ready;

    // Occupancy tracks input-only / output-only transfers.
    always_comb begin
        occ_d = occ_q;
        case ({in_fire_c, out_fire_c})
            2'b10:   occ_d = occ_q + 3'd1;
            2'b01:   occ_d = occ_q - 3'd1;
            default: occ_d = occ_q;
        endcase
    end

    // Occupancy register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q <= 3'd0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occupancy = occ_q;

endmodule
